// File: rtl/hazard_pkg.sv
// hazard_pkg: latency classes, branch opcodes and latency lookup shared by the hazard scoreboard
package hazard_pkg;

    typedef enum logic [1:0] {
        LC_ALU  = 2'd0,
        LC_LOAD = 2'd1,
        LC_MUL  = 2'd2
    } lat_cls_t;

    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_BNE = 6'b000101;

    // The reserved encoding 2'b11 falls through to the load latency.
    function automatic int lat_of(lat_cls_t c, int lat_alu, int lat_load, int lat_mul);
        return c == LC_ALU ? lat_alu : c == LC_MUL ? lat_mul : lat_load;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request and pipeline-control bundle; stall counters present with HAZARD_STATS_EN
interface hazard_scoreboard_if #(parameter int NUM_REGS = 32);
    import hazard_pkg::*;

    localparam int RW = $clog2(NUM_REGS);

    logic          id_valid;
    logic [5:0]    opc;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic          use_rs;
    logic          use_rt;
    logic [RW-1:0] rd;
    logic          rd_we;
    lat_cls_t      lat_cls;
    logic          ext_stall;
    logic          flush;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          SelCtrl;
    logic          hazard;
    logic          issue;
`ifdef HAZARD_STATS_EN
    logic [31:0]   stall_cnt_ld;
    logic [31:0]   stall_cnt_br;

    modport master (
        output id_valid, opc, rs, rt, use_rs, use_rt, rd, rd_we, lat_cls, ext_stall, flush,
        input  PCWrite, IFIDWrite, SelCtrl, hazard, issue, stall_cnt_ld, stall_cnt_br
    );
    modport slave (
        input  id_valid, opc, rs, rt, use_rs, use_rt, rd, rd_we, lat_cls, ext_stall, flush,
        output PCWrite, IFIDWrite, SelCtrl, hazard, issue, stall_cnt_ld, stall_cnt_br
    );
`else
    modport master (
        output id_valid, opc, rs, rt, use_rs, use_rt, rd, rd_we, lat_cls, ext_stall, flush,
        input  PCWrite, IFIDWrite, SelCtrl, hazard, issue
    );
    modport slave (
        input  id_valid, opc, rs, rt, use_rs, use_rt, rd, rd_we, lat_cls, ext_stall, flush,
        output PCWrite, IFIDWrite, SelCtrl, hazard, issue
    );
`endif

endinterface

// File: rtl/hazard_reg_timer.sv
// hazard_reg_timer: per-register countdown until the in-flight result becomes forwardable
module hazard_reg_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    // freeze on hold; a new writer reloads and overrides the decrement
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (!hold)
            cnt <= load ? load_val : cnt != '0 ? cnt - 1'b1 : cnt;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register timer hazard unit beside ID; stall counters when HAZARD_STATS_EN is defined
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int LAT_ALU  = 1,
    parameter int LAT_LOAD = 2,
    parameter int LAT_MUL  = 4,
    parameter int CNT_W    = 3
) (
    input  logic           clk,
    input  logic           rst,
    hazard_scoreboard_if.slave bus
);

    localparam int RW      = $clog2(NUM_REGS);
    localparam int LAT_MAX = LAT_MUL > LAT_LOAD ? (LAT_MUL > LAT_ALU ? LAT_MUL : LAT_ALU)
                                                : (LAT_LOAD > LAT_ALU ? LAT_LOAD : LAT_ALU);

    if (LAT_MAX > 2**CNT_W - 1) begin : g_cnt_w_check
        $error("hazard_scoreboard: CNT_W cannot hold the largest latency");
    end

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] load_val;
    logic             is_br;
    logic             busy_rs;
    logic             busy_rt;
    logic             stall;
    logic             issue;

    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_timer
        hazard_reg_timer #(.CNT_W(CNT_W)) u_timer (
            .clk      (clk),
            .rst      (rst),
            .hold     (bus.ext_stall),
            .load     (issue && bus.rd_we && bus.rd == RW'(r)),
            .load_val (load_val),
            .cnt      (cnt[r])
        );
    end

    // branches need the value in ID (ready at 0), everything else can take it forwarded into EX (ready at 1)
    always_comb begin
        is_br         = bus.opc == OPC_BEQ || bus.opc == OPC_BNE;
        thr           = is_br ? '0 : CNT_W'(1);
        busy_rs       = bus.use_rs && bus.rs != '0 && cnt[bus.rs] > thr;
        busy_rt       = bus.use_rt && bus.rt != '0 && cnt[bus.rt] > thr;
        stall         = bus.id_valid && !bus.flush && (busy_rs || busy_rt);
        issue         = bus.id_valid && !bus.flush && !stall && !bus.ext_stall;
        load_val      = CNT_W'(lat_of(bus.lat_cls, LAT_ALU, LAT_LOAD, LAT_MUL));
        bus.PCWrite   = !(stall || bus.ext_stall);
        bus.IFIDWrite = !(stall || bus.ext_stall);
        bus.SelCtrl   = !stall;
        bus.hazard    = stall && is_br;
        bus.issue     = issue;
    end

`ifdef HAZARD_STATS_EN
    // saturating stall counters split by cause; frozen cycles are not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cnt_ld <= '0;
            bus.stall_cnt_br <= '0;
        end else begin
            if (stall && !bus.ext_stall && !is_br && !(&bus.stall_cnt_ld))
                bus.stall_cnt_ld <= bus.stall_cnt_ld + 32'd1;
            if (stall && !bus.ext_stall && is_br && !(&bus.stall_cnt_br))
                bus.stall_cnt_br <= bus.stall_cnt_br + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus stall-counter sequence for hazard_scoreboard
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    typedef struct {
        string      nm;
        bit         r, v, e, f;
        bit [5:0]   o;
        bit [4:0]   s, t;
        bit         us, ut;
        bit [4:0]   d;
        bit         w;
        bit [1:0]   c;
        bit         p, sl, h, i;
    } vec_t;

    localparam bit [5:0] OR_ = 6'b000000;
    localparam bit [5:0] LW  = 6'b100011;
    localparam bit [5:0] BEQ = 6'b000100;
    localparam bit [5:0] BNE = 6'b000101;
    localparam bit [1:0] ALU = 2'd0;
    localparam bit [1:0] LD  = 2'd1;
    localparam bit [1:0] MUL = 2'd2;
    localparam bit [1:0] RSV = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(32)) bus ();

    hazard_scoreboard #(
        .NUM_REGS (32),
        .LAT_ALU  (1),
        .LAT_LOAD (2),
        .LAT_MUL  (4),
        .CNT_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic vec_t mk(string n, bit r, bit v, bit e, bit f, bit [5:0] o,
                                int s, int t, bit us, bit ut, int d, bit w, bit [1:0] c,
                                bit p, bit sl, bit h, bit i);
        vec_t x;
        x.nm = n; x.r = r; x.v = v; x.e = e; x.f = f; x.o = o;
        x.s = 5'(s); x.t = 5'(t); x.us = us; x.ut = ut; x.d = 5'(d); x.w = w; x.c = c;
        x.p = p; x.sl = sl; x.h = h; x.i = i;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        @(negedge clk);
        rst           = x.r;
        bus.id_valid  = x.v;
        bus.ext_stall = x.e;
        bus.flush     = x.f;
        bus.opc       = x.o;
        bus.rs        = x.s;
        bus.rt        = x.t;
        bus.use_rs    = x.us;
        bus.use_rt    = x.ut;
        bus.rd        = x.d;
        bus.rd_we     = x.w;
        bus.lat_cls   = lat_cls_t'(x.c);
        #2;
    endtask

    task automatic apply(input vec_t x);
        drive(x);
        chk({x.nm, ".PCWrite"},   {31'd0, bus.PCWrite},   {31'd0, x.p});
        chk({x.nm, ".IFIDWrite"}, {31'd0, bus.IFIDWrite}, {31'd0, x.p});
        chk({x.nm, ".SelCtrl"},   {31'd0, bus.SelCtrl},   {31'd0, x.sl});
        chk({x.nm, ".hazard"},    {31'd0, bus.hazard},    {31'd0, x.h});
        chk({x.nm, ".issue"},     {31'd0, bus.issue},     {31'd0, x.i});
    endtask

    initial begin
        // columns: name, rst valid ext flush, opc, rs rt use_rs use_rt, rd rd_we cls, PC/IFID SelCtrl hazard issue
        tbl.push_back(mk("rst",            1,0,0,0, OR_,  0, 0,1,1,  0,0,ALU, 1,1,0,0));
        tbl.push_back(mk("s1_lw",          0,1,0,0, LW,   1, 8,1,0,  8,1,LD,  1,1,0,1));
        tbl.push_back(mk("s1_use_stall",   0,1,0,0, OR_,  8, 9,1,1, 13,1,ALU, 0,0,0,0));
        tbl.push_back(mk("s1_use_go",      0,1,0,0, OR_,  8, 9,1,1, 13,1,ALU, 1,1,0,1));
        tbl.push_back(mk("s2_add",         0,1,0,0, OR_,  1, 2,1,1,  9,1,ALU, 1,1,0,1));
        tbl.push_back(mk("s2_beq_stall",   0,1,0,0, BEQ,  9, 0,1,1,  0,0,ALU, 0,0,1,0));
        tbl.push_back(mk("s2_beq_go",      0,1,0,0, BEQ,  9, 0,1,1,  0,0,ALU, 1,1,0,1));
        tbl.push_back(mk("s3_lw",          0,1,0,0, LW,   1,10,1,0, 10,1,LD,  1,1,0,1));
        tbl.push_back(mk("s3_beq_st1",     0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        tbl.push_back(mk("s3_beq_st2",     0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        tbl.push_back(mk("s3_beq_go",      0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 1,1,0,1));
        tbl.push_back(mk("s3x_lw",         0,1,0,0, LW,   1,10,1,0, 10,1,LD,  1,1,0,1));
        tbl.push_back(mk("s3x_beq_st1",    0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        tbl.push_back(mk("s3x_beq_frozen", 0,1,1,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        tbl.push_back(mk("s3x_beq_st2",    0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        tbl.push_back(mk("s3x_bne_go",     0,1,0,0, BNE, 10,10,1,1,  0,0,ALU, 1,1,0,1));
        tbl.push_back(mk("s4_mul",         0,1,0,0, OR_,  1, 2,1,1, 11,1,MUL, 1,1,0,1));
        tbl.push_back(mk("s4_sub_st1",     0,1,0,0, OR_, 11, 3,1,1, 14,1,ALU, 0,0,0,0));
        tbl.push_back(mk("s4_sub_st2",     0,1,0,0, OR_, 11, 3,1,1, 14,1,ALU, 0,0,0,0));
        tbl.push_back(mk("s4_sub_st3",     0,1,0,0, OR_, 11, 3,1,1, 14,1,ALU, 0,0,0,0));
        tbl.push_back(mk("s4_sub_go",      0,1,0,0, OR_, 11, 3,1,1, 14,1,ALU, 1,1,0,1));
        tbl.push_back(mk("s4_mul2",        0,1,0,0, OR_,  1, 2,1,1, 11,1,MUL, 1,1,0,1));
        tbl.push_back(mk("s4_rt_unused",   0,1,0,0, OR_,  1,11,1,0, 15,1,ALU, 1,1,0,1));
        tbl.push_back(mk("flush",          0,1,0,1, OR_, 11,11,1,1, 15,1,ALU, 1,1,0,0));
        tbl.push_back(mk("idle_busy_src",  0,0,0,0, OR_, 11,11,1,1, 15,1,ALU, 1,1,0,0));
        tbl.push_back(mk("ext_only",       0,1,1,0, OR_,  1, 2,1,1, 15,1,ALU, 0,1,0,0));
        tbl.push_back(mk("s5_lw12",        0,1,0,0, LW,   1,12,1,0, 12,1,LD,  1,1,0,1));
        tbl.push_back(mk("s5_waw_add",     0,1,0,0, OR_,  1, 2,1,1, 12,1,ALU, 1,1,0,1));
        tbl.push_back(mk("s5_or_use",      0,1,0,0, OR_, 12, 0,1,1, 16,1,ALU, 1,1,0,1));
        tbl.push_back(mk("s5_lw_r0",       0,1,0,0, LW,   1, 0,1,0,  0,1,LD,  1,1,0,1));
        tbl.push_back(mk("s5_beq_r0",      0,1,0,0, BEQ,  0, 0,1,1,  0,0,ALU, 1,1,0,1));
        tbl.push_back(mk("rsv_issue",      0,1,0,0, OR_,  1, 2,1,1, 17,1,RSV, 1,1,0,1));
        tbl.push_back(mk("rsv_use_st",     0,1,0,0, OR_, 17, 0,1,1, 18,1,ALU, 0,0,0,0));
        tbl.push_back(mk("rsv_use_go",     0,1,0,0, OR_, 17, 0,1,1, 18,1,ALU, 1,1,0,1));
        tbl.push_back(mk("alu_rt_go",      0,1,0,0, OR_,  0,18,1,1, 19,1,ALU, 1,1,0,1));
        tbl.push_back(mk("self_dep_mul",   0,1,0,0, OR_, 20,20,1,1, 20,1,MUL, 1,1,0,1));
        tbl.push_back(mk("s6_lw",          0,1,0,0, LW,   1, 8,1,0,  8,1,LD,  1,1,0,1));
        tbl.push_back(mk("s6_stall_rst",   1,1,0,0, OR_,  8, 0,1,1, 21,1,ALU, 0,0,0,0));
        tbl.push_back(mk("s6_after_rst",   0,1,0,0, OR_,  8,20,1,1, 21,1,ALU, 1,1,0,1));
        tbl.push_back(mk("s6_beq_cleared", 0,1,0,0, BEQ, 20, 0,1,1,  0,0,ALU, 1,1,0,1));

        rst = 1'b1;
        drive(tbl[0]);
        repeat (2) @(posedge clk);

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k]);

`ifdef HAZARD_STATS_EN
        apply(mk("st_rst",     1,0,0,0, OR_,  0, 0,0,0,  0,0,ALU, 1,1,0,0));
        apply(mk("st_lw",      0,1,0,0, LW,   1,10,1,0, 10,1,LD,  1,1,0,1));
        apply(mk("st_beq_st1", 0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        apply(mk("st_beq_st2", 0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 0,0,1,0));
        apply(mk("st_beq_go",  0,1,0,0, BEQ, 10,10,1,1,  0,0,ALU, 1,1,0,1));
        apply(mk("st_idle",    0,0,0,0, OR_,  0, 0,0,0,  0,0,ALU, 1,1,0,0));
        chk("stall_cnt_br", bus.stall_cnt_br, 32'd2);
        chk("stall_cnt_ld", bus.stall_cnt_ld, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
